rram_host_dispatcher: RTL
=========================

RRAM_HOST_DISPATCHER -- requirements
Module: rram_host_dispatcher

Interface
REQ-001 SHALL have parameters: INSTR_WIDTH 4, instruction field width; OPCODE_WIDTH 16, opcode field width; DATAIN_WIDTH 64, input word width; DATAOUT_WIDTH 64, result word width; MAX_BURST 16, maximum words per burst.
REQ-002 SHALL have ports:
- CLK  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_instr  in  INSTR_WIDTH+OPCODE_WIDTH  instruction word.
- cmd_nin  in  5  input words to forward.
- cmd_nout  in  5  result words to collect.
- hdin_valid  in  1  host data valid.
- hdin_ready  out  1  host data accepted.
- hdin_data  in  DATAIN_WIDTH  host data.
- res_valid  out  1  result valid.
- res_ready  in  1  host accepts result.
- res_data  out  DATAOUT_WIDTH  result word.
- res_last  out  1  final result of command.
- push_n_instFIFO  out  1  active-low push, instruction FIFO.
- full_instFIFO  in  1  instruction FIFO full.
- din_instFIFO  out  INSTR_WIDTH+OPCODE_WIDTH  instruction FIFO write data.
- push_n_iFIFO  out  1  active-low push, input data FIFO.
- full_iFIFO  in  1  input FIFO full.
- din_iFIFO  out  DATAIN_WIDTH  input FIFO write data.
- pop_n_oFIFO  out  1  active-low pop, output data FIFO.
- empty_oFIFO  in  1  output FIFO empty.
- dout_oFIFO  in  DATAOUT_WIDTH  output FIFO head word, valid when empty_oFIFO low.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse on command completion.

Function
REQ-003 SHALL implement states IDLE, INSTR, DATA, RESULT.
REQ-004 IDLE: cmd_ready=1; on cmd_valid, latch cmd_instr, nin=min(cmd_nin,MAX_BURST), nout=min(cmd_nout,MAX_BURST); next state INSTR.
REQ-005 INSTR: push_n_instFIFO = full_instFIFO (combinational); din_instFIFO = latched instr; hold while full.
REQ-006 After instruction push: next DATA if nin>0, else RESULT if nout>0, else IDLE with done.
REQ-007 DATA: hdin_ready = ~full_iFIFO; push_n_iFIFO low exactly when hdin_valid & ~full_iFIFO; din_iFIFO = hdin_data (pass-through); in_cnt increments per push.
REQ-008 After the nin-th push: next RESULT if nout>0, else IDLE with done.
REQ-009 RESULT: single registered result slot.
- pop_n_oFIFO low iff ~empty_oFIFO & popped_cnt<nout & (~res_valid | res_ready).
- On pop: res_data<=dout_oFIFO; res_valid<=1 next cycle; res_last<=1 iff word is the nout-th.
- Full throughput: one word per cycle when res_ready held high.
REQ-010 Result handshake: word consumed on res_valid & res_ready; res_valid/res_data SHALL hold stable until consumed.
REQ-011 RESULT exits to IDLE in the cycle after the last word (res_last) is consumed; done pulses high for one cycle in that cycle.
REQ-012 Push/pop strobes SHALL never assert outside their state; no pushes while full; no pops while empty; no pops beyond nout.
REQ-013 cmd_ready=0, hdin_ready=0 outside IDLE/DATA respectively.
REQ-014 Counters are 5-bit; cmd_nin/cmd_nout >MAX_BURST SHALL be clamped to MAX_BURST; nin=nout=0 completes after the instruction push alone.
REQ-015 Latency: command accepted at edge N -> push_n_instFIFO low in cycle N+1 if not full; first iFIFO push no earlier than cycle N+2.

Reset
REQ-016 On reset low (any time, mid-operation included): state=IDLE, counters=0, res_valid=0, res_last=0, res_data=0, done=0, busy=0; push_n_*=1, pop_n_oFIFO=1 immediately (asynchronous). External FIFO contents untouched.
REQ-017 After reset deassertion, cmd_ready=1 on the first clock cycle.

Verification
REQ-018 Basic: cmd instr=0x1_0A05, nin=2, nout=2, FIFOs never full/empty, res_ready=1 -> one instFIFO push of 0x10A05, two iFIFO pushes of host words in order, two results with res_last on second, done one cycle after, total 7 cycles.
REQ-019 Backpressure: full_instFIFO high 3 cycles after accept -> push_n_instFIFO stays high 3 cycles, pushes on cycle 4; full_iFIFO toggling -> hdin_ready mirrors ~full, no lost/duplicate words.
REQ-020 Result stall: nout=3, res_ready low 4 cycles with oFIFO non-empty -> exactly one pop, res_data stable, remaining two pops after res_ready rises; res_last only on word 3.
REQ-021 Clamp/zero: cmd_nin=20, nout=0 -> exactly 16 iFIFO pushes then done; nin=0,nout=0 -> single instruction push, done next cycle.
REQ-022 Reset mid-DATA after 5 of 8 pushes -> all strobes high immediately, busy=0, cmd_ready=1 after release; new command executes normally.

Source files
------------

// File: rtl/rram_host_dispatcher.sv
// Host-side command dispatcher for an RRAM compute tile: forwards one instruction and a burst
// of input words into the tile FIFOs, then streams result words back through a one-slot buffer.
module rram_host_dispatcher #(
    parameter int unsigned INSTR_WIDTH   = 4,
    parameter int unsigned OPCODE_WIDTH  = 16,
    parameter int unsigned DATAIN_WIDTH  = 64,
    parameter int unsigned DATAOUT_WIDTH = 64,
    parameter int unsigned MAX_BURST     = 16
) (
    input  logic                                CLK,
    input  logic                                reset,

    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic [INSTR_WIDTH+OPCODE_WIDTH-1:0] cmd_instr,
    input  logic [4:0]                          cmd_nin,
    input  logic [4:0]                          cmd_nout,

    input  logic                                hdin_valid,
    output logic                                hdin_ready,
    input  logic [DATAIN_WIDTH-1:0]             hdin_data,

    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [DATAOUT_WIDTH-1:0]            res_data,
    output logic                                res_last,

    output logic                                push_n_instFIFO,
    input  logic                                full_instFIFO,
    output logic [INSTR_WIDTH+OPCODE_WIDTH-1:0] din_instFIFO,

    output logic                                push_n_iFIFO,
    input  logic                                full_iFIFO,
    output logic [DATAIN_WIDTH-1:0]             din_iFIFO,

    output logic                                pop_n_oFIFO,
    input  logic                                empty_oFIFO,
    input  logic [DATAOUT_WIDTH-1:0]            dout_oFIFO,

    output logic                                busy,
    output logic                                done
);

    localparam int unsigned IW       = INSTR_WIDTH + OPCODE_WIDTH;
    localparam logic [4:0]  MaxBurst = 5'(MAX_BURST);

    typedef enum logic [1:0] {
        StIdle,
        StInstr,
        StData,
        StResult
    } state_e;

    state_e                   state_q, state_d;
    logic [IW-1:0]            instr_q, instr_d;
    logic [4:0]               nin_q, nin_d;
    logic [4:0]               nout_q, nout_d;
    logic [4:0]               in_cnt_q, in_cnt_d;
    logic [4:0]               pop_cnt_q, pop_cnt_d;
    logic                     res_valid_q, res_valid_d;
    logic                     res_last_q, res_last_d;
    logic [DATAOUT_WIDTH-1:0] res_data_q, res_data_d;
    logic                     done_q, done_d;

    logic [4:0] in_cnt_inc;
    logic [4:0] pop_cnt_inc;
    logic       res_take;
    logic       pop_ok;

    assign in_cnt_inc  = in_cnt_q + 5'd1;
    assign pop_cnt_inc = pop_cnt_q + 5'd1;
    assign res_take    = res_valid_q & res_ready;
    // The slot may be refilled in the same cycle its current word is taken.
    assign pop_ok      = ~empty_oFIFO & (pop_cnt_q < nout_q) & (~res_valid_q | res_ready);

    always_comb begin
        state_d         = state_q;
        instr_d         = instr_q;
        nin_d           = nin_q;
        nout_d          = nout_q;
        in_cnt_d        = in_cnt_q;
        pop_cnt_d       = pop_cnt_q;
        res_valid_d     = res_valid_q;
        res_last_d      = res_last_q;
        res_data_d      = res_data_q;
        done_d          = 1'b0;
        cmd_ready       = 1'b0;
        hdin_ready      = 1'b0;
        push_n_instFIFO = 1'b1;
        push_n_iFIFO    = 1'b1;
        pop_n_oFIFO     = 1'b1;
        din_instFIFO    = instr_q;
        din_iFIFO       = hdin_data;

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    instr_d   = cmd_instr;
                    nin_d     = (cmd_nin > MaxBurst) ? MaxBurst : cmd_nin;
                    nout_d    = (cmd_nout > MaxBurst) ? MaxBurst : cmd_nout;
                    in_cnt_d  = 5'd0;
                    pop_cnt_d = 5'd0;
                    state_d   = StInstr;
                end
            end

            StInstr: begin
                push_n_instFIFO = full_instFIFO;
                if (!full_instFIFO) begin
                    if (nin_q != 5'd0) begin
                        state_d = StData;
                    end else if (nout_q != 5'd0) begin
                        state_d = StResult;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end

            StData: begin
                hdin_ready = ~full_iFIFO;
                if (hdin_valid && !full_iFIFO) begin
                    push_n_iFIFO = 1'b0;
                    in_cnt_d     = in_cnt_inc;
                    if (in_cnt_inc == nin_q) begin
                        if (nout_q != 5'd0) begin
                            state_d = StResult;
                        end else begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end
                end
            end

            StResult: begin
                if (pop_ok) begin
                    pop_n_oFIFO = 1'b0;
                    pop_cnt_d   = pop_cnt_inc;
                    res_data_d  = dout_oFIFO;
                    res_valid_d = 1'b1;
                    res_last_d  = (pop_cnt_inc == nout_q);
                end else if (res_take) begin
                    res_valid_d = 1'b0;
                    res_last_d  = 1'b0;
                end
                // pop_ok is impossible once the last word sits in the slot.
                if (res_take && res_last_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            instr_q     <= '0;
            nin_q       <= 5'd0;
            nout_q      <= 5'd0;
            in_cnt_q    <= 5'd0;
            pop_cnt_q   <= 5'd0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            res_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            nin_q       <= nin_d;
            nout_q      <= nout_d;
            in_cnt_q    <= in_cnt_d;
            pop_cnt_q   <= pop_cnt_d;
            res_valid_q <= res_valid_d;
            res_last_q  <= res_last_d;
            res_data_q  <= res_data_d;
            done_q      <= done_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_last  = res_last_q;
    assign res_data  = res_data_q;
    assign done      = done_q;
    assign busy      = (state_q != StIdle);

endmodule
